// File: rtl/pipe_collect.sv
`default_nettype none
// ============================================================================
// Module      : pipe_collect
// Description : Aligns scaling-pipe lane results with their enable/coefficient,
//               classifies them and buffers them in a FIFO with drop counting.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_collect #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [1:0]        in_cf,
    input  logic [15:0]       in_data0,
    input  logic [15:0]       in_data1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [1:0]        out_cf,
    output logic [3:0]        out_flags,
    output logic [AW:0]       level,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int                c_EW       = 38;
    localparam logic [AW:0]       c_FULL     = (AW+1)'(DEPTH);
    localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

    logic              r_en_d;
    logic [1:0]        r_cf_d;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [c_EW-1:0]   r_mem [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic              w_drop;
    logic [3:0]        w_flags;
    logic [c_EW-1:0]   w_entry;
    logic [c_EW-1:0]   w_head;

    // The pipe output seen this cycle belongs to last cycle's enable.
    assign w_push  = r_en_d;
    assign w_pop   = out_valid & out_ready;
    assign w_full  = (r_level == c_FULL);
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    assign w_flags = {in_data1 == 16'hFFFF, in_data1 == 16'h0000,
                      in_data0 == 16'hFFFF, in_data0 == 16'h0000};
    assign w_entry = {r_cf_d, w_flags, in_data1, in_data0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en_d     <= 1'b0;
            r_cf_d     <= 2'b00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_en_d <= in_en;
            r_cf_d <= in_cf;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    // Storage is deliberately left uninitialised; the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? w_head[31:0]  : 32'h0;
    assign out_flags = out_valid ? w_head[35:32] : 4'h0;
    assign out_cf    = out_valid ? w_head[37:36] : 2'h0;
    assign level     = r_level;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_collect.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_collect
// Description : Scoreboard bench for pipe_collect with a one-register pipe model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_collect;

    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_en;
    logic [1:0]        in_cf;
    logic [15:0]       raw0, raw1;
    logic [15:0]       in_data0 = '0;
    logic [15:0]       in_data1 = '0;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [1:0]        out_cf;
    logic [3:0]        out_flags;
    logic [AW:0]       level;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Bench-side model state
    logic [37:0] sb[$];
    int          m_level = 0;
    int          m_drop  = 0;
    logic        m_en_d  = 1'b0;
    logic [1:0]  m_cf_d  = 2'b00;

    pipe_collect #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .in_cf     (in_cf),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cf    (out_cf),
        .out_flags (out_flags),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the scaling pipe: registers the lane values on its enable.
    always @(posedge clk) begin
        if (in_en) begin
            in_data0 <= raw0;
            in_data1 <= raw1;
        end
    end

    function automatic logic [3:0] flags_of(input logic [15:0] d0, input logic [15:0] d1);
        return {d1 == 16'hFFFF, d1 == 16'h0000, d0 == 16'hFFFF, d0 == 16'h0000};
    endfunction

    // Drive one cycle of stimulus and advance the reference model across the edge.
    task automatic drive(input logic en, input logic [1:0] cf, input logic [15:0] d0,
                         input logic [15:0] d1, input logic rdy);
        logic        pop, push, rst_now;
        logic [15:0] s0, s1;
        in_en = en; in_cf = cf; raw0 = d0; raw1 = d1; out_ready = rdy;
        #1;
        pop = (m_level != 0) && rdy;
        push = m_en_d;
        s0 = in_data0; s1 = in_data1;
        rst_now = rst_n;
        @(posedge clk);
        if (!rst_now) begin
            sb.delete();
            m_level = 0; m_drop = 0; m_en_d = 1'b0; m_cf_d = 2'b00;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                m_level--;
            end
            if (push) begin
                if (m_level == DEPTH) begin
                    if (m_drop != 255) m_drop++;
                end else begin
                    sb.push_back({m_cf_d, flags_of(s0, s1), s1, s0});
                    m_level++;
                end
            end
            m_en_d = en; m_cf_d = cf;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cf !== 2'd0 || out_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h cf=%0d flags=%b, required 0/0/0/0",
                     out_valid, out_data, out_cf, out_flags);
        end
        checks++;
        if (level !== '0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counts: level=%0d drop=%0d, required 0/0", level, drop_cnt);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 2'd2, 16'h0006, 16'h0020, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_fallthrough: valid=%b, required 0", out_valid);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0020_0006 || out_cf !== 2'd2 ||
            out_flags !== 4'b0000 || level !== 4'd1) begin
            errors++;
            $display("FAIL basic_head: valid=%b data=%h cf=%0d flags=%b level=%0d, required 1/00200006/2/0000/1",
                     out_valid, out_data, out_cf, out_flags, level);
        end
        checks++;
        if (sb.size() != 1 || {out_cf, out_flags, out_data} !== sb[0]) begin
            errors++;
            $display("FAIL basic_scoreboard: got %h, required %h", {out_cf, out_flags, out_data},
                     (sb.size() != 0) ? sb[0] : 38'h0);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
        checks++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: level=%0d valid=%b, required 0/0", level, out_valid);
        end
    endtask

    task automatic test_flags();
        drive(1'b1, 2'd3, 16'h0000, 16'hFFFF, 1'b0);
        drive(1'b1, 2'd1, 16'hFFFF, 16'h0000, 1'b0);
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (out_data !== 32'hFFFF_0000 || out_flags !== 4'b1001 || out_cf !== 2'd3) begin
            errors++;
            $display("FAIL flags_first: data=%h flags=%b cf=%0d, required FFFF0000/1001/3",
                     out_data, out_flags, out_cf);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
        checks++;
        if (out_data !== 32'h0000_FFFF || out_flags !== 4'b0110 || out_cf !== 2'd1) begin
            errors++;
            $display("FAIL flags_second: data=%h flags=%b cf=%0d, required 0000FFFF/0110/1",
                     out_data, out_flags, out_cf);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_overflow();
        int drained = 0;
        for (int i = 0; i < 10; i++)
            drive(1'b1, 2'(i), 16'(16'h0100 + i), 16'(16'h0A00 + 3 * i), 1'b0);
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (level !== 4'd8 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overflow_level: level=%0d drop=%0d, required 8/2", level, drop_cnt);
        end
        for (int k = 0; k < 20 && out_valid; k++) begin
            checks++;
            if (out_data !== {16'(16'h0A00 + 3 * drained), 16'(16'h0100 + drained)} ||
                out_cf !== 2'(drained) || sb.size() == 0 || {out_cf, out_flags, out_data} !== sb[0]) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: data=%h cf=%0d, required %h/%0d", drained,
                         out_data, out_cf, {16'(16'h0A00 + 3 * drained), 16'(16'h0100 + drained)}, drained % 4);
            end
            drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
            drained++;
        end
        checks++;
        if (drained != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_count: drained=%0d valid=%b, required 8/0", drained, out_valid);
        end
    endtask

    task automatic test_stream();
        int drop0;
        for (int i = 0; i < 9; i++)
            drive(1'b1, 2'(i), 16'(16'h2000 + i), 16'(16'h3000 + i), 1'b0);
        drop0 = m_drop;
        checks++;
        if (level !== 4'd8) begin
            errors++;
            $display("FAIL stream_full: level=%0d, required 8", level);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (level !== 4'd8 || int'(drop_cnt) != drop0 || sb.size() == 0 ||
                {out_cf, out_flags, out_data} !== sb[0]) begin
                errors++;
                $display("FAIL stream[%0d]: level=%0d drop=%0d head=%h, required 8/%0d/%h", i, level,
                         drop_cnt, {out_cf, out_flags, out_data}, drop0, (sb.size() != 0) ? sb[0] : 38'h0);
            end
            drive(1'b1, 2'(i + 1), 16'(16'h4000 + i), 16'(16'h5000 + 7 * i), 1'b1);
        end
        for (int k = 0; k < 20 && (out_valid || m_level != 0); k++) begin
            checks++;
            if (sb.size() == 0 || {out_cf, out_flags, out_data} !== sb[0]) begin
                errors++;
                $display("FAIL stream_drain[%0d]: head=%h, required %h", k, {out_cf, out_flags, out_data},
                         (sb.size() != 0) ? sb[0] : 38'h0);
            end
            drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 2'd1, 16'(16'h0700 + i), 16'h0007, 1'b0);
        drive(1'b1, 2'd2, 16'hDEAD, 16'hBEEF, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 16'hCAFE, 16'hF00D, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL resetmid_empty: valid=%b level=%0d, required 0/0", out_valid, level);
        end
        drive(1'b1, 2'd3, 16'h1234, 16'h5678, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL resetmid_nocapture: valid=%b level=%0d, required 0/0", out_valid, level);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5678_1234 || out_cf !== 2'd3 || level !== 4'd1) begin
            errors++;
            $display("FAIL resetmid_first: valid=%b data=%h cf=%0d level=%0d, required 1/56781234/3/1",
                     out_valid, out_data, out_cf, level);
        end
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_drop_sat();
        for (int i = 0; i < 309; i++)
            drive(1'b1, 2'd0, 16'(i), 16'h0001, 1'b0);
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (drop_cnt !== 8'd255 || int'(drop_cnt) != m_drop || level !== 4'd8) begin
            errors++;
            $display("FAIL drop_saturate: drop=%0d level=%0d, required 255/8", drop_cnt, level);
        end
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'd0, 16'h0, 16'h0, 1'b0);
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_hold: drop=%0d, required 255", drop_cnt);
        end
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if (drop_cnt !== 8'd0 || level !== 4'd0) begin
            errors++;
            $display("FAIL drop_reset: drop=%0d level=%0d, required 0/0", drop_cnt, level);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_en = 1'b0; in_cf = 2'd0; raw0 = '0; raw1 = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_flags();
        test_overflow();
        test_stream();
        test_reset_mid();
        test_drop_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_collect.md
Name: pipe_collect

Overview:
- Downstream stage of the scaling pipe. Consumes the pipe's two 16-bit lane outputs, which arrive one cycle after the enable that produced them.
- Aligns each result with its originating enable and coefficient, classifies each lane, and buffers packed results in a FIFO.
- Presents FIFO contents to the consumer over a valid/ready handshake, and counts results dropped on overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, pointer width; must equal log2(DEPTH).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_en  in  1  same enable driven to the pipe's i_en this cycle.
- in_cf  in  2  same coefficient driven to the pipe's i_cf this cycle.
- in_data0  in  16  pipe lane-0 output.
- in_data1  in  16  pipe lane-1 output.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  32  {lane1, lane0} of head entry.
- out_cf  out  2  coefficient tagged to head entry.
- out_flags  out  4  {d1==FFFF, d1==0000, d0==FFFF, d0==0000} of head entry.
- level  out  AW+1  current occupancy, 0..DEPTH.
- drop_cnt  out  DROP_W  saturating count of dropped results.

Behaviour:
- Reset (rst_n low at posedge):
  - en_d=0, cf_d=0; read/write pointers=0, level=0, drop_cnt=0.
  - Outputs: out_valid=0, out_data=0, out_cf=0, out_flags=0.
  - FIFO memory is not cleared. When out_valid=0, out_data, out_cf and out_flags are forced to 0.
- Alignment:
  - en_d<=in_en and cf_d<=in_cf every cycle.
  - push = en_d. A push samples in_data0/in_data1 in the cycle en_d=1, i.e. the pipe output registered from the in_en one cycle earlier.
- Entry format: 38 bits = {cf_d, flags[3:0], in_data1, in_data0}. Flags are computed combinationally from the sampled lane data.
- Latency: in_en=1 at cycle N → written at the posedge ending N+1 → out_valid=1 in N+2 (no fall-through). Back-to-back in_en gives one push per cycle.
- Pop:
  - pop = out_valid & out_ready.
  - Head is read combinationally from mem[rd_ptr].
  - out_valid = (level!=0).
- Occupancy:
  - push only: level+1.
  - pop only: level-1.
  - push & pop: level unchanged, both pointers advance.
- Full (level==DEPTH):
  - push without pop: entry dropped, pointers unchanged, drop_cnt+1.
  - push with pop: push accepted, no drop.
- drop_cnt saturates at 2^DROP_W-1 and clears only on reset.
- Empty: pop impossible because out_valid=0. out_ready is ignored when empty.
- Pointers wrap modulo DEPTH. level distinguishes full from empty.
- Reset mid-operation:
  - FIFO is emptied and en_d is cleared.
  - A pipe result from an in_en sampled in the cycle before reset is NOT captured.
  - The first capturable enable is one sampled on or after the first cycle with rst_n high.
- Ordering: strict FIFO, no reordering, no duplication.

Test Plan:
1. Reset, then in_en=1, cf=2, data0=0003, data1=0010 (pipe outputs 0006/0020) → out_valid=1 two cycles after in_en; out_data=0x00200006, out_cf=2, out_flags=0000, level=1. Then out_ready=1 → level=0, out_valid=0.
2. Passthrough values, cf=3, lane inputs 0000/FFFF → out_data=0xFFFF0000, out_flags=1001.
3. out_ready=0, 10 consecutive enables with DEPTH=8 → level stops at 8; drop_cnt=2; drained sequence is the first 8 results in order.
4. FIFO full, out_ready=1 and enable streaming continuously → level holds at 8, drop_cnt unchanged, one pop per cycle matching push order through pointer wrap.
5. Three entries buffered, rst_n low one cycle while in_en=1 → out_valid=0 and level=0 immediately after. The result of the pre-reset enable never appears; first post-reset enable appears two cycles later.
6. Force 300 drops with out_ready=0 → drop_cnt=255 and stays; reset → 0.
